// File: rtl/crypt_decoder_if.sv
// -----------------------------------------------------------------------------
// crypt_decoder_if
// Data-memory bus between the decryption stage and the shared byte memory.
//   mem_addr   : byte address driven by the decoder
//   mem_rd_en  : read request; mem_rdata returns on the following cycle
//   mem_rdata  : read data returned by the memory
//   mem_wr_en  : single-cycle write strobe
//   mem_wdata  : write data
// The master modport is the decoder side, slave is the memory side.
// -----------------------------------------------------------------------------
interface crypt_decoder_if;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;

    modport master (
        output mem_addr,
        output mem_rd_en,
        output mem_wr_en,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        input  mem_wr_en,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/crypt_decoder.sv
// -----------------------------------------------------------------------------
// crypt_decoder
// Recovers the LFSR tap pattern and seed of a parity-tagged ciphertext stored
// at addresses 64..127 from its known space preamble, decrypts all 64 bytes and
// writes the message with the leading spaces removed to addresses 0..63, then
// back-fills the tail with spaces.
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset, returns to IDLE
//   start          : run launches on its falling edge while in IDLE or DONE
//   mem            : data-memory bus (crypt_decoder_if.master)
//   ack            : high while in DONE
//   pt_found       : index 0..8 of the recovered tap pattern
//   no_match       : no tap pattern reproduces the preamble
//   parity_err_cnt : ciphertext bytes whose bit 7 differs from ^bits[6:0]
// -----------------------------------------------------------------------------
module crypt_decoder (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    crypt_decoder_if.master mem,
    output logic            ack,
    output logic [3:0]      pt_found,
    output logic            no_match,
    output logic [6:0]      parity_err_cnt
);

    localparam logic [7:0] MSG_BASE   = 8'd0;
    localparam logic [7:0] CRYPT_BASE = 8'd64;
    localparam logic [6:0] SPACE7     = 7'h20;
    localparam logic [7:0] SPACE8     = 8'h20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_PAD    = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Candidate tap patterns, searched in index order.
    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        case (idx)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] taps);
        lfsr_step = {s[5:0], ^(s & taps)};
    endfunction

    // High when the tag bit disagrees with the XOR of the payload bits.
    function automatic logic parity_bad(input logic [7:0] b);
        parity_bad = b[7] ^ (^b[6:0]);
    endfunction

    // A candidate fits when stepping from k[0] reproduces k[1..9] in order.
    function automatic logic cand_match(input logic [6:0] taps, input logic [9:0][6:0] k);
        logic [6:0] st;
        logic       ok;
        st = k[0];
        ok = 1'b1;
        for (int j = 1; j < 10; j++) begin
            st = lfsr_step(st, taps);
            ok = ok & (st == k[j]);
        end
        cand_match = ok;
    endfunction

    logic [2:0]       state_r;
    logic [6:0]       cnt_r;
    logic             phase_r;       // DECODE: 0 = read cycle, 1 = process cycle
    logic [9:0][6:0]  key_r;         // key_r[j] = preamble ciphertext j ^ space
    logic [6:0]       lfsr_r;
    logic             found_r;
    logic             skip_r;
    logic [6:0]       skip_cnt_r;
    logic             start_d_r;
    logic             ack_r;
    logic [3:0]       pt_found_r;
    logic             no_match_r;
    logic [6:0]       perr_r;
    logic [7:0]       mem_addr_r;
    logic             mem_rd_en_r;
    logic             pad_wr_r;

    logic             launch_s;
    logic             cand_hit_s;
    logic [7:0]       plain_s;
    logic             is_space_s;
    logic             dec_wr_s;
    logic [6:0]       skip_next_s;
    logic [7:0]       wdata_s;

    // Launch decode, candidate evaluation and DECODE process-cycle write decision.
    // The write in a process cycle depends on the byte returned in that same
    // cycle, so strobe and data come straight from mem_rdata; the address was
    // registered one cycle earlier.
    always_comb begin
        launch_s    = start_d_r & ~start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
        cand_hit_s  = cand_match(tap_of(cnt_r[3:0]), key_r);
        plain_s     = {1'b0, mem.mem_rdata[6:0] ^ lfsr_r};
        is_space_s  = (plain_s[6:0] == SPACE7);
        dec_wr_s    = (state_r == ST_DECODE) & phase_r & (~skip_r | ~is_space_s);
        skip_next_s = skip_cnt_r + {6'd0, skip_r & is_space_s};
        if (dec_wr_s) begin
            wdata_s = plain_s;
        end else if (pad_wr_r) begin
            wdata_s = SPACE8;
        end else begin
            wdata_s = 8'd0;
        end
    end

    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_rd_en = mem_rd_en_r;
    assign mem.mem_wr_en = dec_wr_s | pad_wr_r;
    assign mem.mem_wdata = wdata_s;

    assign ack            = ack_r;
    assign pt_found       = pt_found_r;
    assign no_match       = no_match_r;
    assign parity_err_cnt = perr_r;

    // Main sequencer: LOAD, SEARCH, DECODE, PAD and the registered bus controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 7'd0;
            phase_r     <= 1'b0;
            key_r       <= '0;
            lfsr_r      <= 7'd0;
            found_r     <= 1'b0;
            skip_r      <= 1'b0;
            skip_cnt_r  <= 7'd0;
            start_d_r   <= 1'b0;
            ack_r       <= 1'b0;
            pt_found_r  <= 4'd0;
            no_match_r  <= 1'b0;
            perr_r      <= 7'd0;
            mem_addr_r  <= 8'd0;
            mem_rd_en_r <= 1'b0;
            pad_wr_r    <= 1'b0;
        end else begin
            start_d_r <= start;
            if (launch_s) begin
                state_r     <= ST_LOAD;
                cnt_r       <= 7'd0;
                phase_r     <= 1'b0;
                found_r     <= 1'b0;
                skip_r      <= 1'b1;
                skip_cnt_r  <= 7'd0;
                ack_r       <= 1'b0;
                pt_found_r  <= 4'd0;
                no_match_r  <= 1'b0;
                perr_r      <= 7'd0;
                mem_addr_r  <= CRYPT_BASE;
                mem_rd_en_r <= 1'b1;
                pad_wr_r    <= 1'b0;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        // Reads go out on counts 0..9, data lands one count later;
                        // shifting in from the top leaves byte 0 in key_r[0].
                        if (cnt_r != 7'd0) begin
                            key_r <= {mem.mem_rdata[6:0] ^ SPACE7, key_r[9:1]};
                        end
                        if (cnt_r < 7'd9) begin
                            mem_addr_r  <= CRYPT_BASE + {1'b0, cnt_r} + 8'd1;
                            mem_rd_en_r <= 1'b1;
                        end else begin
                            mem_addr_r  <= 8'd0;
                            mem_rd_en_r <= 1'b0;
                        end
                        if (cnt_r == 7'd10) begin
                            state_r <= ST_SEARCH;
                            cnt_r   <= 7'd0;
                        end else begin
                            cnt_r <= cnt_r + 7'd1;
                        end
                    end
                    ST_SEARCH: begin
                        // All nine candidates are visited; only the first hit is kept.
                        if (!found_r && cand_hit_s) begin
                            found_r    <= 1'b1;
                            pt_found_r <= cnt_r[3:0];
                        end
                        if (cnt_r == 7'd8) begin
                            if (found_r || cand_hit_s) begin
                                state_r     <= ST_DECODE;
                                cnt_r       <= 7'd0;
                                phase_r     <= 1'b0;
                                lfsr_r      <= key_r[0];
                                mem_addr_r  <= CRYPT_BASE;
                                mem_rd_en_r <= 1'b1;
                            end else begin
                                state_r    <= ST_DONE;
                                no_match_r <= 1'b1;
                                pt_found_r <= 4'd0;
                                ack_r      <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 7'd1;
                        end
                    end
                    ST_DECODE: begin
                        if (!phase_r) begin
                            // Skip count only moves at process-cycle ends, so the
                            // destination for this byte is already known here.
                            phase_r     <= 1'b1;
                            mem_rd_en_r <= 1'b0;
                            mem_addr_r  <= MSG_BASE + {1'b0, cnt_r} - {1'b0, skip_cnt_r};
                        end else begin
                            lfsr_r     <= lfsr_step(lfsr_r, tap_of(pt_found_r));
                            skip_cnt_r <= skip_next_s;
                            phase_r    <= 1'b0;
                            if (parity_bad(mem.mem_rdata)) begin
                                perr_r <= perr_r + 7'd1;
                            end
                            if (skip_r && !is_space_s) begin
                                skip_r <= 1'b0;
                            end
                            if (cnt_r == 7'd63) begin
                                if (skip_next_s == 7'd0) begin
                                    state_r    <= ST_DONE;
                                    ack_r      <= 1'b1;
                                    mem_addr_r <= 8'd0;
                                end else begin
                                    state_r    <= ST_PAD;
                                    cnt_r      <= 7'd64 - skip_next_s;
                                    mem_addr_r <= MSG_BASE + {1'b0, 7'd64 - skip_next_s};
                                    pad_wr_r   <= 1'b1;
                                end
                            end else begin
                                cnt_r       <= cnt_r + 7'd1;
                                mem_addr_r  <= CRYPT_BASE + {1'b0, cnt_r} + 8'd1;
                                mem_rd_en_r <= 1'b1;
                            end
                        end
                    end
                    ST_PAD: begin
                        // One space per cycle up to the last message address.
                        if (cnt_r == 7'd63) begin
                            state_r    <= ST_DONE;
                            ack_r      <= 1'b1;
                            pad_wr_r   <= 1'b0;
                            mem_addr_r <= 8'd0;
                        end else begin
                            cnt_r      <= cnt_r + 7'd1;
                            mem_addr_r <= mem_addr_r + 8'd1;
                        end
                    end
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crypt_decoder.sv
// -----------------------------------------------------------------------------
// tb_crypt_decoder
// Directed bench for crypt_decoder: builds ciphertext with a reference
// encryptor, queues the expected memory writes, then checks every write,
// the completion timing and the status outputs.
// -----------------------------------------------------------------------------
module tb_crypt_decoder;

    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                        7'h69, 7'h5C, 7'h7E, 7'h7B};

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ack;
    logic [3:0] pt_found;
    logic       no_match;
    logic [6:0] parity_err_cnt;

    logic [7:0] crypt_mem [64];
    logic [7:0] msg_mem   [64];
    logic [7:0] plain     [64];
    logic [7:0] exp_img   [64];
    bit         clr_msg = 1'b0;
    wr_t        exp_q [$];

    int checks   = 0;
    int failures = 0;

    crypt_decoder_if bus ();

    crypt_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mem            (bus),
        .ack            (ack),
        .pt_found       (pt_found),
        .no_match       (no_match),
        .parity_err_cnt (parity_err_cnt)
    );

    always #5 clk = ~clk;

    // Byte memory: registered read, message region writable.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rdata <= (bus.mem_addr >= 8'd64) ? crypt_mem[bus.mem_addr[5:0]]
                                                     : msg_mem[bus.mem_addr[5:0]];
        end
        if (clr_msg) begin
            for (int a = 0; a < 64; a++) msg_mem[a] <= 8'hEE;
        end else if (bus.mem_wr_en && (bus.mem_addr < 8'd64)) begin
            msg_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Reference encryptor plus expected write list and final image.
    task automatic build(input string msg, input int pre, input int pat,
                         input logic [6:0] init, input bit expect_writes);
        logic [6:0] st;
        logic [6:0] c;
        int         s;
        for (int i = 0; i < 64; i++) plain[i] = 8'h20;
        for (int i = 0; i < msg.len(); i++) plain[pre + i] = 8'(msg[i]);
        st = init;
        for (int i = 0; i < 64; i++) begin
            c = plain[i][6:0] ^ st;
            crypt_mem[i] = {^c, c};
            st = step(st, TAPS[pat]);
        end
        exp_q.delete();
        s = 0;
        while (s < 64 && plain[s] == 8'h20) s++;
        for (int i = 0; i < 64; i++) exp_img[i] = expect_writes ? 8'h20 : 8'hEE;
        if (expect_writes) begin
            for (int i = s; i < 64; i++) begin
                exp_img[i - s] = plain[i];
                exp_q.push_back('{rd: 1'b0, addr: 8'(i - s), data: plain[i]});
            end
            for (int a = 64 - s; a < 64; a++) begin
                exp_q.push_back('{rd: 1'b0, addr: 8'(a), data: 8'h20});
            end
        end
    endtask

    task automatic clear_msg();
        @(negedge clk) clr_msg = 1'b1;
        @(negedge clk) clr_msg = 1'b0;
    endtask

    // Ends just after the edge that sees start fall, i.e. at the start of cycle 0.
    task automatic launch();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
    endtask

    // One cycle of observation: every write must match the scoreboard head.
    task automatic mon_cycle(output bit ack_seen);
        wr_t got;
        wr_t want;
        @(negedge clk);
        if (bus.mem_wr_en) begin
            got  = '{rd: bus.mem_rd_en, addr: bus.mem_addr, data: bus.mem_wdata};
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk("mem_write", 32'(got), 32'(want));
        end
        ack_seen = ack;
    endtask

    task automatic run_check(input string tag, input int exp_cyc, input logic [3:0] exp_pt,
                             input logic exp_nm, input logic [6:0] exp_perr, input bit chk_pt);
        int cyc;
        int bad;
        bit a;
        bit hold;
        launch();
        cyc = -1;
        for (int c = 0; c < 400; c++) begin
            mon_cycle(a);
            if (a) begin
                cyc = c;
                break;
            end
        end
        chk({tag, "_ack_cycle"}, 32'(cyc), 32'(exp_cyc));
        if (chk_pt) chk({tag, "_pt_found"}, 32'(pt_found), 32'(exp_pt));
        chk({tag, "_no_match"}, 32'(no_match), 32'(exp_nm));
        chk({tag, "_parity_cnt"}, 32'(parity_err_cnt), 32'(exp_perr));
        chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (msg_mem[i] !== exp_img[i]) bad++;
        chk({tag, "_image_bad_bytes"}, 32'(bad), 32'd0);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mon_cycle(a);
            hold = hold & a;
        end
        chk({tag, "_ack_hold"}, 32'(hold), 32'd1);
    endtask

    initial begin
        string gold;
        string watson;
        bit    a;
        bit    seen;
        gold   = " Knowledge comes, but wisdom lingers.    ";
        watson = "Mr. Watson, come here. I want to see you.";
        rst    = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({ack, pt_found, no_match, parity_err_cnt, bus.mem_rd_en, bus.mem_wr_en,
                 bus.mem_addr, bus.mem_wdata}), 32'd0);
        rst = 1'b0;

        build(gold, 12, 0, 7'h17, 1'b1);
        clear_msg();
        run_check("golden", 161, 4'd0, 1'b0, 7'd0, 1'b1);

        build(watson, 10, 8, 7'h01, 1'b1);
        clear_msg();
        run_check("pat8", 158, 4'd8, 1'b0, 7'd0, 1'b1);

        build(gold, 12, 0, 7'h17, 1'b1);
        crypt_mem[20][7] = ~crypt_mem[20][7];
        clear_msg();
        run_check("parity", 161, 4'd0, 1'b0, 7'd1, 1'b1);

        build(gold, 12, 0, 7'h17, 1'b0);
        crypt_mem[5] = crypt_mem[5] ^ 8'h01;
        clear_msg();
        run_check("nomatch", 20, 4'd0, 1'b1, 7'd0, 1'b1);

        build("", 0, 3, 7'h2A, 1'b1);
        clear_msg();
        run_check("spaces", 212, 4'd0, 1'b0, 7'd0, 1'b0);

        // Abort the golden run in the middle of DECODE.
        build(gold, 12, 0, 7'h17, 1'b1);
        clear_msg();
        launch();
        for (int c = 0; c <= 100; c++) mon_cycle(a);
        chk("pre_reset_read", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, 8'd104}));
        #1 rst = 1'b1;
        #1;
        chk("reset_async",
            32'({ack, pt_found, no_match, parity_err_cnt, bus.mem_rd_en, bus.mem_wr_en,
                 bus.mem_addr, bus.mem_wdata}), 32'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = seen | bus.mem_rd_en | bus.mem_wr_en | ack;
        end
        chk("idle_after_reset", 32'(seen), 32'd0);

        build(gold, 12, 0, 7'h17, 1'b1);
        run_check("rerun", 161, 4'd0, 1'b0, 7'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
